// File: rtl/issue_ctrl.sv
// Single-entry issue stage with a register scoreboard: holds one decoded instruction for
// execute, stalls decode on RAW/WAW hazards against in-flight destinations.
module issue_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic        dec_wr_rd,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic        ex_wr,
    input  logic        ex_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic [31:0] busy,
    output logic        stalled,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    state_e      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_wr_q, ex_wr_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] pend_vec;
    logic        hazard;
    logic        handoff;
    logic        blocked;

    // Registered scoreboard plus the held destination; writeback is not bypassed.
    always_comb begin
        pend_vec = busy_q;
        if (ex_valid_q && ex_wr_q) begin
            pend_vec[ex_rd_q] = 1'b1;
        end
        pend_vec[0] = 1'b0;
        hazard = (dec_use_rs1 & pend_vec[dec_rs1]) |
                 (dec_use_rs2 & pend_vec[dec_rs2]) |
                 (dec_wr_rd   & pend_vec[dec_rd]);
        dec_ready = reset_n & dec_valid & (state_q != StFlush) & ~flush & ~hazard &
                    (~ex_valid_q | ex_ready);
        handoff = ex_valid_q & ex_ready & ex_wr_q & ~flush;
        blocked = dec_valid & hazard & ~flush;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ex_wr_d    = ex_wr_q;
        if (dec_ready) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = dec_rd;
            ex_wr_d    = dec_wr_rd & (dec_rd != 5'd0);
        end else if (flush || (ex_valid_q && ex_ready)) begin
            ex_valid_d = 1'b0;
        end

        // Set is applied after clear so a same-cycle handoff wins.
        busy_d = busy_q;
        if (wb_valid && wb_rd != 5'd0) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (handoff) begin
            busy_d[ex_rd_q] = 1'b1;
        end
        busy_d[0] = 1'b0;

        stall_cnt_d = stall_cnt_q;
        if (blocked && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StFlush;
        end else begin
            unique case (state_q)
                StRun:   if (dec_valid && hazard) state_d = StStall;
                StStall: if (!hazard || !dec_valid) state_d = StRun;
                StFlush: state_d = StRun;
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StRun;
            busy_q      <= 32'd0;
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_wr_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_rd     = ex_rd_q;
    assign ex_wr     = ex_wr_q;
    assign busy      = busy_q;
    assign stalled   = (state_q == StStall);
    assign stall_cnt = stall_cnt_q;

endmodule
